// File: rtl/cmp2_cascade_seq_if.sv
// rtl/cmp2_cascade_seq_if.sv - digit input and word result handshake bundle for cmp2_cascade_seq
interface cmp2_cascade_seq_if #(
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS);

    logic          in_valid;
    logic          in_ready;
    logic          A_gt_B;
    logic          A_lt_B;
    logic          A_eq_B;
    logic          abort;
    logic [CW-1:0] digit_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_gt;
    logic          out_lt;
    logic          out_eq;
    logic          out_err;

    modport master (
        output in_valid, A_gt_B, A_lt_B, A_eq_B, abort, out_ready,
        input  in_ready, digit_idx, out_valid, out_gt, out_lt, out_eq, out_err
    );

    modport slave (
        input  in_valid, A_gt_B, A_lt_B, A_eq_B, abort, out_ready,
        output in_ready, digit_idx, out_valid, out_gt, out_lt, out_eq, out_err
    );
endinterface

// File: rtl/cmp2_cascade_seq.sv
// rtl/cmp2_cascade_seq.sv - MSB-first sequential cascade of 2-bit comparator digit results
module cmp2_cascade_seq #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    cmp2_cascade_seq_if.slave  bus
);
    localparam int CW = $clog2(DIGITS);

    typedef enum logic {COLLECT, HOLD} state_t;
    typedef enum logic [1:0] {DEC_EQ, DEC_GT, DEC_LT} dec_t;

    state_t        state;
    dec_t          dec;
    dec_t          dec_next;
    logic          err;
    logic          err_next;
    logic          legal;
    logic          last;
    logic [CW-1:0] idx;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_gt_q;
    logic          out_lt_q;
    logic          out_eq_q;
    logic          out_err_q;

    always_comb begin
        legal    = ({bus.A_gt_B, bus.A_lt_B, bus.A_eq_B} == 3'b100) ||
                   ({bus.A_gt_B, bus.A_lt_B, bus.A_eq_B} == 3'b010) ||
                   ({bus.A_gt_B, bus.A_lt_B, bus.A_eq_B} == 3'b001);
        err_next = err | ~legal;
        last     = (idx == CW'(DIGITS - 1));
        dec_next = dec;
        // The first non-equal digit, most significant first, settles the word
        if (dec == DEC_EQ) begin
            if (bus.A_gt_B)      dec_next = DEC_GT;
            else if (bus.A_lt_B) dec_next = DEC_LT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            dec         <= DEC_EQ;
            err         <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_gt_q    <= 1'b0;
            out_lt_q    <= 1'b0;
            out_eq_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.abort) begin
                        idx <= '0;
                        dec <= DEC_EQ;
                        err <= 1'b0;
                    end else if (bus.in_valid) begin
                        if (last) begin
                            state       <= HOLD;
                            idx         <= '0;
                            dec         <= DEC_EQ;
                            err         <= 1'b0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_err_q   <= err_next;
                            out_gt_q    <= !err_next && (dec_next == DEC_GT);
                            out_lt_q    <= !err_next && (dec_next == DEC_LT);
                            out_eq_q    <= !err_next && (dec_next == DEC_EQ);
                        end else begin
                            idx <= idx + CW'(1);
                            dec <= dec_next;
                            err <= err_next;
                        end
                    end
                end
                HOLD: begin
                    // in_ready rises only after the result leaves, so no digit is taken on the release cycle
                    if (bus.out_ready) begin
                        state       <= COLLECT;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_gt_q    <= 1'b0;
                        out_lt_q    <= 1'b0;
                        out_eq_q    <= 1'b0;
                        out_err_q   <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.digit_idx = idx;
    assign bus.out_valid = out_valid_q;
    assign bus.out_gt    = out_gt_q;
    assign bus.out_lt    = out_lt_q;
    assign bus.out_eq    = out_eq_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: doc/cmp2_cascade_seq.md
Name: cmp2_cascade_seq

Overview:
- Sequential cascade stage directly downstream of the 2-bit magnitude comparator slice.
- Consumes one per-digit result (A_gt_B / A_lt_B / A_eq_B) per accepted cycle, most-significant 2-bit digit first.
- Resolves the magnitude relation of a DIGITS×2-bit word and presents it to the consumer under a valid/ready handshake.
- Lets the team compare wide operands by time-multiplexing a single 2-bit slice.

Parameters:
DIGITS, 4, number of 2-bit digit pairs per word (word width = 2*DIGITS bits); legal range 2..256
CW, $clog2(DIGITS), width of the digit index counter (derived; not overridden)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  the slice flags on A_gt_B/A_lt_B/A_eq_B this cycle are valid
in_ready  output  1  the block accepts a digit this cycle
A_gt_B  input  1  current digit: A digit > B digit
A_lt_B  input  1  current digit: A digit < B digit
A_eq_B  input  1  current digit: A digit == B digit
abort  input  1  synchronous discard of the partially collected word
digit_idx  output  CW  index of the next digit to accept (0 = MSB digit)
out_valid  output  1  word result is valid and held
out_ready  input  1  consumer accepts the result
out_gt  output  1  word A > word B
out_lt  output  1  word A < word B
out_eq  output  1  word A == word B
out_err  output  1  an illegal flag combination was seen in this word

Behaviour:
- Reset (async, rst=1): state=COLLECT, decision=EQ, err=0, digit_idx=0, out_valid=0, out_gt=0, out_lt=0, out_eq=0, out_err=0, in_ready=1. Reset takes effect immediately, including mid-word and during HOLD; a partial word is lost.
- A digit is accepted when in_valid && in_ready.
- Legal digit: exactly one of A_gt_B, A_lt_B, A_eq_B is 1. Any other combination is illegal and sets err for the current word.
- The state machine has two states, COLLECT and HOLD.
- In COLLECT, in_ready=1 and out_valid=0.
- On each accepted digit in COLLECT:
  - Decision update: if decision==EQ, decision becomes GT if A_gt_B, LT if A_lt_B, and stays EQ if A_eq_B. Once decision is GT or LT, later digits do not change it; they are still counted and checked for legality.
  - Counting: digit_idx increments; it wraps to 0 on acceptance of digit DIGITS-1.
  - Last digit (digit DIGITS-1, with its own flags included): go to HOLD. On the next edge, out_valid=1. If err=0, the output is one-hot {out_gt,out_lt,out_eq} per the final decision and out_err=0. If err=1, out_gt=out_lt=out_eq=0 and out_err=1.
  - The decision register and err are cleared to EQ/0 on the same edge that enters HOLD.
- Latency: 1 cycle from acceptance of the last digit to out_valid=1.
- In HOLD:
  - in_ready=0.
  - Outputs are stable while out_valid && !out_ready.
  - On out_valid && out_ready: next edge out_valid=0, all result outputs return to 0, and the state returns to COLLECT. in_ready=1 from that cycle on, so there is no same-cycle re-accept.
  - Minimum word period is DIGITS+1 cycles.
- abort:
  - In COLLECT: next edge digit_idx=0, decision=EQ, err=0. Any digit presented in the same cycle is discarded, so abort wins over in_valid.
  - In HOLD: ignored; the pending result is unaffected.
- in_valid=0 in COLLECT: all state holds; gaps between digits are allowed.
- Flags are sampled only on acceptance; flag values while in_valid=0 or in_ready=0 are don't-care.

Test Plan:
- Ordered compare (DIGITS=4, no stalls): A=8'b10_01_11_00, B=8'b10_01_10_11 → digits eq,eq,gt,lt → one cycle after 4th accept: out_valid=1, out_gt=1, out_lt=0, out_eq=0, out_err=0.
- Equal and less: A=B=8'hA5 → out_eq=1 only. Then A=8'h3F, B=8'h40 → first digit lt → out_lt=1 only. All other digits ignored for the decision.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, and in_valid digits are not accepted (digit_idx stays 0). out_ready=1 → out_valid=0 next edge and in_ready=1.
- Illegal flags: 2nd digit presented as A_gt_B=1, A_lt_B=1 (other digits legal) → out_err=1, out_gt=out_lt=out_eq=0. The next word (A=B) produces a clean out_eq=1 with err cleared.
- Abort and gaps: accept 2 digits (gt first), assert abort with in_valid=1 → digit_idx=0 and the digit is dropped. Then feed 4 eq digits with random in_valid gaps → out_eq=1.
- Async reset mid-word: assert rst between clock edges after 3 digits → all outputs 0 and in_ready=1 immediately. After release, a fresh 4-digit word gives a correct result.
